// File: rtl/text_mode_renderer.sv
// text_mode_renderer: 80x30 text-mode pixel pipeline reading char/attr RAM and font ROM,
// applying the CGA palette and an underline blinking cursor, with timing delayed to match rgb.
module text_mode_renderer #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    input  logic        pix_de,
    input  logic        pix_hsync,
    input  logic        pix_vsync,
    input  logic [6:0]  cursor_x,
    input  logic [4:0]  cursor_y,
    input  logic        cursor_en,
    output logic [11:0] video_char_addr,
    input  logic [7:0]  video_char_data,
    input  logic [7:0]  video_attr_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [7:0]  rgb_r,
    output logic [7:0]  rgb_g,
    output logic [7:0]  rgb_b,
    output logic        out_de,
    output logic        out_hsync,
    output logic        out_vsync
);
    localparam int CW = $clog2(BLINK_FRAMES + 1);

    typedef struct packed {
        logic [2:0] x;
        logic [3:0] row;
        logic       de;
        logic       hs;
        logic       vs;
        logic       in_range;
        logic       hit;
    } side_t;

    side_t s1, s2, s3, s4, s0;
    logic [7:0] attr3, attr4;
    logic [CW-1:0] blink_cnt;
    logic blink_phase, vs_d;
    logic [11:0] col_c, row_c;
    logic pix_bit;
    logic [3:0] idx;
    logic [23:0] rgb_c;

    function automatic logic [23:0] cga(input logic [3:0] i);
        logic [7:0] hi, lo;
        hi = i[3] ? 8'hFF : 8'hAA;
        lo = i[3] ? 8'h55 : 8'h00;
        return (i == 4'd6) ? 24'hAA5500 : {i[2] ? hi : lo, i[1] ? hi : lo, i[0] ? hi : lo};
    endfunction

    always_comb begin
        col_c = {4'b0, pix_x[10:3]};
        row_c = {5'b0, pix_y[10:4]};
        s0.x        = pix_x[2:0];
        s0.row      = pix_y[3:0];
        s0.de       = pix_de;
        s0.hs       = pix_hsync;
        s0.vs       = pix_vsync;
        s0.in_range = (col_c < 12'(COLS)) && (row_c < 12'(ROWS));
        s0.hit      = cursor_en & blink_phase & (col_c == {5'b0, cursor_x})
                    & (row_c == {7'b0, cursor_y}) & (pix_y[3:0] >= 4'd14);
        pix_bit = font_data[3'd7 - s4.x];
        idx     = !s4.in_range ? 4'd0 : (s4.hit | pix_bit) ? attr4[3:0] : attr4[7:4];
        rgb_c   = s4.de ? cga(idx) : 24'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            s4 <= '0;
            attr3 <= '0;
            attr4 <= '0;
            video_char_addr <= '0;
            font_addr <= '0;
            {rgb_r, rgb_g, rgb_b} <= '0;
            {out_de, out_hsync, out_vsync} <= '0;
        end else begin
            video_char_addr <= row_c * 12'(COLS) + col_c;
            s1 <= s0;
            s2 <= s1;
            // RAM data is valid while s2 is current, ROM data while s4 is current
            font_addr <= {video_char_data, s2.row};
            attr3 <= video_attr_data;
            s3 <= s2;
            attr4 <= attr3;
            s4 <= s3;
            {rgb_r, rgb_g, rgb_b} <= rgb_c;
            {out_de, out_hsync, out_vsync} <= {s4.de, s4.hs, s4.vs};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d <= 1'b0;
            blink_cnt <= '0;
            blink_phase <= 1'b1;
        end else begin
            vs_d <= pix_vsync;
            if (pix_vsync && !vs_d) begin
                blink_cnt <= (blink_cnt == CW'(BLINK_FRAMES - 1)) ? '0 : blink_cnt + 1'b1;
                blink_phase <= (blink_cnt == CW'(BLINK_FRAMES - 1)) ? ~blink_phase : blink_phase;
            end
        end
    end
endmodule

// File: tb/tb_text_mode_renderer.sv
// tb_text_mode_renderer: directed checks of addressing, latency, palette, cursor blink,
// range handling, sync delay and mid-frame reset for text_mode_renderer.
module tb_text_mode_renderer;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [10:0] pix_x = 0, pix_y = 0;
    logic        pix_de = 0, pix_hsync = 0, pix_vsync = 0;
    logic [6:0]  cursor_x = 7'd2;
    logic [4:0]  cursor_y = 5'd2;
    logic        cursor_en = 0;
    logic [11:0] video_char_addr, font_addr;
    logic [7:0]  video_char_data = 0, video_attr_data = 0, font_data = 0;
    logic [7:0]  rgb_r, rgb_g, rgb_b;
    logic        out_de, out_hsync, out_vsync;
    logic [7:0]  attr_val = 0, font_val = 0;
    int n_chk = 0, n_fail = 0;

    text_mode_renderer dut (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_de(pix_de),
        .pix_hsync(pix_hsync), .pix_vsync(pix_vsync), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .cursor_en(cursor_en), .video_char_addr(video_char_addr), .video_char_data(video_char_data),
        .video_attr_data(video_attr_data), .font_addr(font_addr), .font_data(font_data),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b), .out_de(out_de), .out_hsync(out_hsync),
        .out_vsync(out_vsync)
    );

    always #5 clk = ~clk;

    // One-cycle-latency RAM/ROM models; only cell 162 holds 'A'
    always @(posedge clk) begin
        video_char_data <= (video_char_addr == 12'd162) ? 8'h41 : 8'h20;
        video_attr_data <= attr_val;
        font_data <= font_val;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_vs(input int n);
        repeat (n) begin
            pix_vsync = 1;
            tick();
            pix_vsync = 0;
            tick();
        end
    endtask

    initial begin
        #2;
        chk("reset_rgb", {rgb_r, rgb_g, rgb_b}, 24'h0);
        chk("reset_de", out_de, 1'b0);
        chk("reset_addr", video_char_addr, 12'h0);
        chk("reset_font_addr", font_addr, 12'h0);
        @(negedge clk) rst_n = 1;
        tick();

        pix_x = 17; pix_y = 35; pix_de = 1;
        tick();
        chk("char_addr", video_char_addr, 12'd162);
        tick(2);
        chk("font_addr", font_addr, 12'h413);

        attr_val = 8'h1E; font_val = 8'h80;
        tick(4);
        pix_x = 16;
        tick();
        pix_x = 17;
        tick(4);
        chk("rgb_x0_fg", {rgb_r, rgb_g, rgb_b}, 24'hFFFF55);
        chk("de_active", out_de, 1'b1);
        tick();
        chk("rgb_x1_bg", {rgb_r, rgb_g, rgb_b}, 24'h0000AA);

        font_val = 8'hFF; pix_de = 0;
        tick(6);
        chk("rgb_de0", {rgb_r, rgb_g, rgb_b}, 24'h0);
        chk("de_off", out_de, 1'b0);
        pix_de = 1;
        tick(6);
        chk("rgb_all_fg", {rgb_r, rgb_g, rgb_b}, 24'hFFFF55);
        pix_x = 640;
        tick(6);
        chk("rgb_x640", {rgb_r, rgb_g, rgb_b}, 24'h0);
        chk("de_x640", out_de, 1'b1);
        pix_x = 100; pix_y = 480;
        tick(6);
        chk("rgb_y480", {rgb_r, rgb_g, rgb_b}, 24'h0);

        cursor_en = 1; font_val = 8'h00; attr_val = 8'h07;
        pix_x = 16; pix_y = 46;
        tick(6);
        chk("cursor_row14", {rgb_r, rgb_g, rgb_b}, 24'hAAAAAA);
        pix_y = 45;
        tick(6);
        chk("cursor_row13", {rgb_r, rgb_g, rgb_b}, 24'h0);
        pix_y = 47;
        tick(6);
        chk("cursor_row15", {rgb_r, rgb_g, rgb_b}, 24'hAAAAAA);
        pix_x = 24; pix_y = 46;
        tick(6);
        chk("cursor_wrong_col", {rgb_r, rgb_g, rgb_b}, 24'h0);
        pix_x = 16;
        pulse_vs(29);
        tick(6);
        chk("blink_29", {rgb_r, rgb_g, rgb_b}, 24'hAAAAAA);
        pulse_vs(1);
        tick(6);
        chk("blink_30", {rgb_r, rgb_g, rgb_b}, 24'h0);

        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("midreset_rgb", {rgb_r, rgb_g, rgb_b}, 24'h0);
        chk("midreset_de", out_de, 1'b0);
        chk("midreset_addr", video_char_addr, 12'h0);
        chk("midreset_font_addr", font_addr, 12'h0);
        @(negedge clk) rst_n = 1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("post_reset_de_%0d", i), out_de, 1'b0);
        end
        tick();
        chk("post_reset_de_5", out_de, 1'b1);
        chk("post_reset_blink", {rgb_r, rgb_g, rgb_b}, 24'hAAAAAA);
        cursor_en = 0;
        tick(6);
        chk("cursor_disabled", {rgb_r, rgb_g, rgb_b}, 24'h0);

        pix_de = 0;
        tick(6);
        pix_hsync = 1; pix_vsync = 1;
        tick();
        pix_hsync = 0; pix_vsync = 0;
        tick(3);
        chk("hsync_n4", out_hsync, 1'b0);
        chk("vsync_n4", out_vsync, 1'b0);
        tick();
        chk("hsync_n5", out_hsync, 1'b1);
        chk("vsync_n5", out_vsync, 1'b1);
        tick();
        chk("hsync_n6", out_hsync, 1'b0);
        chk("vsync_n6", out_vsync, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
